request_encoder: RTL and testbench

- Sequential 32-to-5 encoder; the inverse of the 5-to-32 register enable decoder.
- Collects 32 one-hot request lines into a sticky pending register.
- Selects one pending index and presents it as a 5-bit address with a valid/ack handshake.
- Sits between per-register or per-source request lines and the single consumer that services one address at a time.

---
 rtl/request_encoder.sv | 111 +++++++++++
 tb/tb_request_encoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/request_encoder.sv
// request_encoder
//   Sequential 32-to-5 encoder. Request lines are OR'ed into a sticky pending
//   register; one eligible (pending & mask) index is granted at a time and
//   presented as a 5-bit address with a valid/ack handshake.
//
//   Parameters
//     ROUND_ROBIN : 0 = fixed priority (lowest index wins)
//                   1 = round-robin, search starts just after the last grant
//
//   Ports
//     clk         rising-edge clock
//     reset       synchronous, active-high reset
//     request     per-index request lines, OR'ed into pending every edge
//     mask        per-index enable; pending bit eligible only when mask is 1
//     ack         consumer accepts the presented address
//     address     encoded index of the granted request (registered)
//     valid       address is meaningful and awaiting ack (registered)
//     pending     sticky pending register
//     any_pending OR-reduction of pending, unmasked (registered)
module request_encoder #(
  parameter int unsigned ROUND_ROBIN = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] request,
  input  logic [31:0] mask,
  input  logic        ack,
  output logic [4:0]  address,
  output logic        valid,
  output logic [31:0] pending,
  output logic        any_pending
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t      state;
  logic [4:0]  last;
  logic [31:0] eligible;
  logic [31:0] clr;
  logic [31:0] pending_next;
  logic [4:0]  idx;
  logic [4:0]  sel;
  logic        sel_found;

  // Clear only the index that is actually being acknowledged; a request on
  // the same index at the same edge re-sets it because request is OR'ed last.
  always_comb begin
    eligible = pending & mask;
    clr      = '0;
    if (state == PRESENT && ack) begin
      clr[address] = 1'b1;
    end
    pending_next = (pending & ~clr) | request;
  end

  // Round-robin scans last+1 .. last (mod 32), so the previous winner is
  // checked last; fixed priority scans 0 .. 31.
  always_comb begin
    idx       = '0;
    sel       = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (ROUND_ROBIN != 0) begin
        idx = last + 5'(i + 1);
      end else begin
        idx = 5'(i);
      end
      if (!sel_found && eligible[idx]) begin
        sel       = idx;
        sel_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      address     <= '0;
      valid       <= 1'b0;
      pending     <= '0;
      any_pending <= 1'b0;
      last        <= 5'd31;
    end else begin
      pending     <= pending_next;
      any_pending <= |pending_next;
      case (state)
        IDLE: begin
          if (sel_found) begin
            state   <= PRESENT;
            address <= sel;
            valid   <= 1'b1;
            if (ROUND_ROBIN != 0) begin
              last <= sel;
            end
          end
        end
        PRESENT: begin
          // Address holds through the ack so the consumer sees a stable value.
          if (ack) begin
            state <= IDLE;
            valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_request_encoder.sv
module tb_request_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] request;
  logic [31:0] mask;
  logic        ack_fp, ack_rr;
  logic [4:0]  addr_fp, addr_rr;
  logic        vld_fp, vld_rr;
  logic [31:0] pend_fp, pend_rr;
  logic        anyp_fp, anyp_rr;

  int tests = 0;
  int fails = 0;

  // Reference model state, index 0 = fixed priority, 1 = round-robin
  logic [31:0] m_pend[2];
  logic        m_valid[2];
  logic [4:0]  m_addr[2];
  int          m_last[2];

  // Scoreboard: expected grants, and a log of observed grants
  int q_fp[$];
  int q_rr[$];
  int got_fp[$];
  int got_rr[$];
  logic pv_fp = 1'b0;
  logic pv_rr = 1'b0;

  always #5 clk = ~clk;

  request_encoder #(.ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .reset(reset), .request(request), .mask(mask), .ack(ack_fp),
    .address(addr_fp), .valid(vld_fp), .pending(pend_fp), .any_pending(anyp_fp)
  );

  request_encoder #(.ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .reset(reset), .request(request), .mask(mask), .ack(ack_rr),
    .address(addr_rr), .valid(vld_rr), .pending(pend_rr), .any_pending(anyp_rr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m]  = '0;
      m_valid[m] = 1'b0;
      m_addr[m]  = '0;
      m_last[m]  = 31;
    end
  endtask

  // One clock edge of the behaviour, computed from the rules directly.
  task automatic model_step(input int m, input logic [31:0] req, input logic [31:0] msk,
                            input logic a, input logic rst);
    logic [31:0] elig;
    logic [31:0] clr;
    int pick;
    int idx;
    if (rst) begin
      m_pend[m]  = '0;
      m_valid[m] = 1'b0;
      m_addr[m]  = '0;
      m_last[m]  = 31;
      return;
    end
    clr = '0;
    if (m_valid[m]) begin
      if (a) begin
        clr[m_addr[m]] = 1'b1;
        m_valid[m] = 1'b0;
      end
    end else begin
      elig = m_pend[m] & msk;
      pick = -1;
      for (int k = 0; k < 32; k++) begin
        idx = (m == 1) ? (m_last[m] + 1 + k) % 32 : k;
        if (pick < 0 && elig[idx]) pick = idx;
      end
      if (pick >= 0) begin
        m_valid[m] = 1'b1;
        m_addr[m]  = 5'(pick);
        if (m == 1) m_last[m] = pick;
        if (m == 0) q_fp.push_back(pick);
        else        q_rr.push_back(pick);
      end
    end
    m_pend[m] = (m_pend[m] & ~clr) | req;
  endtask

  task automatic check_all();
    chk("valid_fp",   32'(vld_fp),  32'(m_valid[0]));
    chk("addr_fp",    32'(addr_fp), 32'(m_addr[0]));
    chk("pending_fp", pend_fp,      m_pend[0]);
    chk("anyp_fp",    32'(anyp_fp), 32'(|m_pend[0]));
    chk("valid_rr",   32'(vld_rr),  32'(m_valid[1]));
    chk("addr_rr",    32'(addr_rr), 32'(m_addr[1]));
    chk("pending_rr", pend_rr,      m_pend[1]);
    chk("anyp_rr",    32'(anyp_rr), 32'(|m_pend[1]));
  endtask

  // am: 0 = no ack, 1 = ack whatever the model says is presented, 2 = random
  task automatic step(input logic [31:0] req, input logic [31:0] msk,
                      input logic rst, input int am);
    logic a0, a1;
    case (am)
      0:       begin a0 = 1'b0;       a1 = 1'b0;       end
      1:       begin a0 = m_valid[0]; a1 = m_valid[1]; end
      default: begin a0 = 1'($urandom_range(0, 1)); a1 = 1'($urandom_range(0, 1)); end
    endcase
    request = req;
    mask    = msk;
    reset   = rst;
    ack_fp  = a0;
    ack_rr  = a1;
    model_step(0, req, msk, a0, rst);
    model_step(1, req, msk, a1, rst);
    @(negedge clk);
    check_all();
  endtask

  // Grant monitor: every rising valid must match the next expected grant.
  always @(negedge clk) begin
    int e;
    if (vld_fp && !pv_fp) begin
      if (q_fp.size() == 0) begin
        tests++; fails++;
        $display("FAIL grant_fp: got address %0d, expected no grant", addr_fp);
      end else begin
        e = q_fp.pop_front();
        chk("grant_fp", 32'(addr_fp), e);
        got_fp.push_back(int'(addr_fp));
      end
    end
    if (vld_rr && !pv_rr) begin
      if (q_rr.size() == 0) begin
        tests++; fails++;
        $display("FAIL grant_rr: got address %0d, expected no grant", addr_rr);
      end else begin
        e = q_rr.pop_front();
        chk("grant_rr", 32'(addr_rr), e);
        got_rr.push_back(int'(addr_rr));
      end
    end
    pv_fp = vld_fp;
    pv_rr = vld_rr;
  end

  initial begin
    reset = 1'b1; request = '0; mask = '1; ack_fp = 1'b0; ack_rr = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    step('0, '1, 1'b1, 0);

    // Single request, full handshake
    step(32'h1, '1, 1'b0, 0);
    chk("d1_pending", pend_fp, 32'h1);
    step('0, '1, 1'b0, 0);
    chk("d1_valid", 32'(vld_fp), 32'h1);
    chk("d1_addr",  32'(addr_fp), 32'h0);
    step('0, '1, 1'b0, 1);
    chk("d1_valid_after_ack", 32'(vld_fp), 32'h0);
    chk("d1_pending_after_ack", pend_fp, 32'h0);
    chk("d1_any_after_ack", 32'(anyp_fp), 32'h0);

    // Two requests, lowest first, then nothing left
    got_fp.delete(); got_rr.delete();
    step(32'h8000_0010, '1, 1'b0, 1);
    for (int i = 0; i < 7; i++) step('0, '1, 1'b0, 1);
    chk("d2_fp_count", got_fp.size(), 2);
    if (got_fp.size() == 2) begin
      chk("d2_fp_first", got_fp[0], 4);
      chk("d2_fp_second", got_fp[1], 31);
    end
    chk("d2_valid_end", 32'(vld_fp), 32'h0);

    // All requests held: RR rotates, fixed priority sticks at 0
    step('0, '1, 1'b1, 0);
    got_fp.delete(); got_rr.delete();
    for (int i = 0; i < 69; i++) step('1, '1, 1'b0, 1);
    chk("d3_rr_count", got_rr.size(), 34);
    chk("d3_fp_count", got_fp.size(), 34);
    for (int j = 0; j < 34 && j < got_rr.size(); j++) chk("d3_rr_seq", got_rr[j], j % 32);
    for (int j = 0; j < 34 && j < got_fp.size(); j++) chk("d3_fp_seq", got_fp[j], 0);
    step('0, '1, 1'b1, 0);

    // Masked pending bit waits until unmasked
    step(32'h20, 32'hFFFF_FFDF, 1'b0, 1);
    chk("d4_pending", pend_rr, 32'h20);
    for (int i = 0; i < 10; i++) begin
      step('0, 32'hFFFF_FFDF, 1'b0, 1);
      chk("d4_masked_valid", 32'(vld_fp | vld_rr), 32'h0);
    end
    step('0, '1, 1'b0, 1);
    chk("d4_valid", 32'(vld_fp & vld_rr), 32'h1);
    chk("d4_addr", 32'(addr_rr), 32'h5);
    step('0, '1, 1'b0, 1);

    // Ack and re-request of the same index at one edge: set wins
    step(32'h80, '1, 1'b0, 0);
    step('0, '1, 1'b0, 0);
    chk("d5_addr", 32'(addr_fp), 32'h7);
    step(32'h80, '1, 1'b0, 1);
    chk("d5_valid_after_ack", 32'(vld_fp), 32'h0);
    chk("d5_pending_kept", pend_fp, 32'h80);
    step('0, '1, 1'b0, 0);
    chk("d5_regrant", 32'(vld_fp & vld_rr), 32'h1);
    chk("d5_regrant_addr", 32'(addr_rr), 32'h7);
    step('0, '1, 1'b0, 1);

    // Reset mid-presentation, request at the reset edge discarded
    step(32'h300, '1, 1'b0, 0);
    step('0, '1, 1'b0, 0);
    chk("d6_valid", 32'(vld_rr), 32'h1);
    chk("d6_pending", pend_rr, 32'h300);
    step(32'h4, '1, 1'b1, 0);
    chk("d6_rst_valid", 32'(vld_rr), 32'h0);
    chk("d6_rst_addr", 32'(addr_rr), 32'h0);
    chk("d6_rst_pending", pend_rr, 32'h0);
    step(32'h3, '1, 1'b0, 0);
    step('0, '1, 1'b0, 0);
    chk("d6_rr_first", 32'(addr_rr), 32'h0);
    step('0, '1, 1'b0, 1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [31:0] r, mk;
      logic rs;
      r  = $urandom & $urandom & $urandom & $urandom;
      mk = ~($urandom & $urandom);
      rs = ($urandom_range(0, 99) == 0);
      step(r, mk, rs, 2);
    end

    step('0, '1, 1'b1, 0);
    @(negedge clk);
    chk("q_fp_empty", q_fp.size(), 0);
    chk("q_rr_empty", q_rr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
